// File: rtl/priority_arbiter.sv
// Fixed-priority arbiter: bit 0 of r wins. Grant is presented combinationally
// (one-hot, binary index, any, remaining requests) and as a registered copy.
module priority_arbiter #(
    parameter int unsigned n  = 8,
    parameter int unsigned IW = $clog2(n)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [n-1:0]  r,
    output logic [n-1:0]  g,
    output logic [IW-1:0] g_idx,
    output logic          any,
    output logic [n-1:0]  rem,
    output logic [n-1:0]  g_q,
    output logic [IW-1:0] g_idx_q,
    output logic          any_q
);

    logic found;

    // Scan upward and stop at the first set bit, so bits above the winner
    // (even unknown ones) never reach g or g_idx.
    always_comb begin
        g     = '0;
        g_idx = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < n; i++) begin
            if (!found && r[i]) begin
                g[i]  = 1'b1;
                g_idx = IW'(i);
                found = 1'b1;
            end
        end
    end

    assign any = |r;
    assign rem = r & ~g;

    // Registered copy; reset clears only these registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            g_q     <= '0;
            g_idx_q <= '0;
            any_q   <= 1'b0;
        end else begin
            g_q     <= g;
            g_idx_q <= g_idx;
            any_q   <= any;
        end
    end

endmodule

// File: tb/tb_priority_arbiter.sv
// Self-checking bench for priority_arbiter (n = 8) against an r & -r model.
module tb_priority_arbiter;

    localparam int unsigned N  = 8;
    localparam int unsigned IW = $clog2(N);

    logic          clk;
    logic          reset;
    logic [N-1:0]  r;
    logic [N-1:0]  g;
    logic [IW-1:0] g_idx;
    logic          any;
    logic [N-1:0]  rem;
    logic [N-1:0]  g_q;
    logic [IW-1:0] g_idx_q;
    logic          any_q;

    int errors = 0;
    int checks = 0;

    priority_arbiter #(.n(N)) dut (
        .clk(clk), .reset(reset), .r(r), .g(g), .g_idx(g_idx), .any(any),
        .rem(rem), .g_q(g_q), .g_idx_q(g_idx_q), .any_q(any_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: lowest set bit via two's complement, index via log2 of a power of two.
    function automatic logic [N-1:0] ref_g(input logic [N-1:0] x);
        return x & (~x + N'(1));
    endfunction

    function automatic logic [IW-1:0] ref_idx(input logic [N-1:0] x);
        return IW'($clog2(ref_g(x)));
    endfunction

    // Packs the expected combinational outputs as {g, g_idx, any, rem}.
    function automatic logic [2*N+IW:0] ref_comb(input logic [N-1:0] x);
        return {ref_g(x), ref_idx(x), x != '0, x & ~ref_g(x)};
    endfunction

    task automatic test_reset();
        r     = '0;
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({g_q, g_idx_q, any_q} !== '0) begin
            errors++;
            $display("FAIL reset_regs got g_q=%b g_idx_q=%0d any_q=%b want zeros", g_q, g_idx_q, any_q);
        end
        checks++;
        if ({g, g_idx, any, rem} !== ref_comb(r)) begin
            errors++;
            $display("FAIL reset_idle got g=%b g_idx=%0d any=%b rem=%b want zeros", g, g_idx, any, rem);
        end
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [N-1:0]  tr [9] = '{8'h01, 8'h89, 8'h2D, 8'h48, 8'h21, 8'h71, 8'h80, 8'h00, 8'hFF};
        logic [N-1:0]  tg [9] = '{8'h01, 8'h01, 8'h01, 8'h08, 8'h01, 8'h01, 8'h80, 8'h00, 8'h01};
        logic [IW-1:0] ti [9] = '{3'd0,  3'd0,  3'd0,  3'd3,  3'd0,  3'd0,  3'd7,  3'd0,  3'd0};
        for (int k = 0; k < 9; k++) begin
            r = tr[k];
            #5;
            checks++;
            if ({g, g_idx, any, rem} !== {tg[k], ti[k], tr[k] != '0, tr[k] & ~tg[k]}) begin
                errors++;
                $display("FAIL directed r=%b got g=%b g_idx=%0d any=%b rem=%b want g=%b g_idx=%0d",
                         tr[k], g, g_idx, any, rem, tg[k], ti[k]);
            end
        end
    endtask

    task automatic test_sweep();
        for (int v = 0; v < 256; v++) begin
            r = N'(v);
            #1;
            checks++;
            if ({g, g_idx, any, rem} !== ref_comb(r)) begin
                errors++;
                $display("FAIL sweep r=%b got g=%b g_idx=%0d any=%b rem=%b want %b",
                         r, g, g_idx, any, rem, ref_comb(r));
            end
            checks++;
            if (!$onehot0(g) || ((g & ~r) != '0)) begin
                errors++;
                $display("FAIL sweep_shape r=%b got g=%b want one-hot-or-zero subset of r", r, g);
            end
        end
    endtask

    task automatic test_x_above();
        r = {4'bxxxx, 4'b1000};
        #5;
        checks++;
        if ({g, g_idx, any} !== {8'h08, 3'd3, 1'b1}) begin
            errors++;
            $display("FAIL x_above got g=%b g_idx=%0d any=%b want g=00001000 g_idx=3 any=1", g, g_idx, any);
        end
    endtask

    task automatic test_registered();
        @(negedge clk) r = '0;
        @(negedge clk) r = 8'h48;
        #1;
        checks++;
        if ({g_q, g_idx_q, any_q} !== '0) begin
            errors++;
            $display("FAIL reg_hold got g_q=%b g_idx_q=%0d any_q=%b want zeros", g_q, g_idx_q, any_q);
        end
        @(negedge clk);
        checks++;
        if ({g_q, g_idx_q, any_q} !== {8'h08, 3'd3, 1'b1}) begin
            errors++;
            $display("FAIL reg_capture got g_q=%b g_idx_q=%0d any_q=%b want 00001000 3 1", g_q, g_idx_q, any_q);
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk) #2 reset = 1'b1;
        #1;
        checks++;
        if ({g_q, g_idx_q, any_q} !== '0) begin
            errors++;
            $display("FAIL async_reset got g_q=%b g_idx_q=%0d any_q=%b want zeros", g_q, g_idx_q, any_q);
        end
        checks++;
        if (g !== 8'h08) begin
            errors++;
            $display("FAIL reset_comb got g=%b want 00001000", g);
        end
        @(posedge clk) #1;
        checks++;
        if ({g_q, g_idx_q, any_q} !== '0) begin
            errors++;
            $display("FAIL reset_held got g_q=%b g_idx_q=%0d any_q=%b want zeros", g_q, g_idx_q, any_q);
        end
        @(negedge clk) reset = 1'b0;
        r = 8'h80;
        #1;
        checks++;
        if ({g_q, g_idx_q, any_q} !== '0) begin
            errors++;
            $display("FAIL release_wait got g_q=%b g_idx_q=%0d any_q=%b want zeros", g_q, g_idx_q, any_q);
        end
        @(posedge clk) #1;
        checks++;
        if ({g_q, g_idx_q, any_q} !== {8'h80, 3'd7, 1'b1}) begin
            errors++;
            $display("FAIL release_capture got g_q=%b g_idx_q=%0d any_q=%b want 10000000 7 1", g_q, g_idx_q, any_q);
        end
    endtask

    task automatic test_drain();
        logic [N-1:0] want [4] = '{8'h01, 8'h10, 8'h20, 8'h40};
        r = 8'h71;
        for (int k = 0; k < 4; k++) begin
            #5;
            checks++;
            if (g !== want[k]) begin
                errors++;
                $display("FAIL drain step%0d got g=%b want %b", k, g, want[k]);
            end
            r = rem;
        end
        #5;
        checks++;
        if ({any, g} !== '0) begin
            errors++;
            $display("FAIL drain_end got any=%b g=%b want 0", any, g);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] prev;
        @(negedge clk) r = N'($urandom);
        for (int k = 0; k < 200; k++) begin
            #1;
            checks++;
            if ({g, g_idx, any, rem} !== ref_comb(r)) begin
                errors++;
                $display("FAIL rand_comb r=%b got g=%b g_idx=%0d any=%b rem=%b want %b",
                         r, g, g_idx, any, rem, ref_comb(r));
            end
            prev = r;
            @(negedge clk);
            checks++;
            if ({g_q, g_idx_q, any_q} !== {ref_g(prev), ref_idx(prev), prev != '0}) begin
                errors++;
                $display("FAIL rand_reg r=%b got g_q=%b g_idx_q=%0d any_q=%b", prev, g_q, g_idx_q, any_q);
            end
            r = ($urandom_range(0, 3) == 0) ? N'(1 << $urandom_range(0, N-1)) : N'($urandom);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_sweep();
        test_x_above();
        test_registered();
        test_async_reset();
        test_drain();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
